// File: rtl/key_debounce_if.sv
// Purpose : groups the key channel signals (raw buttons in, debounced level and strobes out).
// Latency : none, wires only.
// Backpressure: none; all signals are level/strobe, no handshake.
//
// Ports / modports:
//   master - button side: drives key_in, observes key_out / press_pulse / release_pulse
//   slave  - debouncer side: samples key_in, drives key_out / press_pulse / release_pulse
interface key_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] key_in;         // raw asynchronous buttons, active-low
    logic [WIDTH-1:0] key_out;        // debounced level, active-low
    logic [WIDTH-1:0] press_pulse;    // one-cycle strobe on key_out 1->0
    logic [WIDTH-1:0] release_pulse;  // one-cycle strobe on key_out 0->1

    modport master (
        output key_in,
        input  key_out,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  key_in,
        output key_out,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// Purpose : synchronise and debounce WIDTH active-low push buttons; emit clean level + press/release strobes.
// Latency : input stable before edge E1 -> key_out (and its strobe) changes on edge E(DEBOUNCE_CYCLES+2).
// Backpressure: none; free-running, every channel evaluated every cycle.
//
// Ports:
//   clk      - system clock
//   reset_n  - synchronous active-low reset
//   bus      - key_debounce_if.slave: key_in in, key_out / press_pulse / release_pulse out
module key_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    key_debounce_if.slave       bus
);

    // Terminal count: the cycle on which a still-differing input is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;             // first synchroniser stage (nothing else reads it)
    logic [WIDTH-1:0] s2;             // second synchroniser stage, safe to use in logic
    logic [CNT_W-1:0] cnt [WIDTH];    // per-channel stability counters
    logic [WIDTH-1:0] key_out_q;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] release_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Released state everywhere; any in-progress count is thrown away.
            s1        <= '1;
            s2        <= '1;
            key_out_q <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= bus.key_in;
            s2 <= s1;
            for (int i = 0; i < WIDTH; i++) begin
                // Strobes are single-cycle: cleared unless the accept branch fires.
                press_q[i]   <= 1'b0;
                release_q[i] <= 1'b0;
                if (s2[i] == key_out_q[i]) begin
                    // Input agrees with the output (or bounced back): restart the count.
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    // Differing input held long enough: accept it and strobe the edge.
                    key_out_q[i] <= s2[i];
                    cnt[i]       <= '0;
                    press_q[i]   <= ~s2[i];
                    release_q[i] <= s2[i];
                end else begin
                    // Below CNT_MAX here, so the counter can never wrap.
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.key_out       = key_out_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Purpose : directed self-checking bench for key_debounce with DEBOUNCE_CYCLES=4, WIDTH=4.
// Latency : expects key_out change on the 6th edge after key_in changes.
// Backpressure: n/a.
module tb_key_debounce;

    localparam int WIDTH = 4;
    localparam int DC    = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   press_cnt [WIDTH];
    int   release_cnt [WIDTH];

    always #5 clk = ~clk;

    key_debounce_if #(.WIDTH(WIDTH)) kif ();

    key_debounce #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(kif.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < WIDTH; i++) begin
            press_cnt[i]   = 0;
            release_cnt[i] = 0;
        end
    endtask

    // Advance one edge, sample 1 ns later, accumulate strobes, and check exclusivity.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < WIDTH; i++) begin
            if (kif.press_pulse[i] === 1'b1)   press_cnt[i]++;
            if (kif.release_pulse[i] === 1'b1) release_cnt[i]++;
        end
        check("pulse_excl", 32'(kif.press_pulse & kif.release_pulse), 32'h0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        clear_counts();
        kif.key_in = 4'b0000;
        reset_n    = 1'b0;

        // 1. Reset held 3 cycles with keys low
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_key_out", 32'(kif.key_out), 32'hF);
            check("rst_press", 32'(kif.press_pulse), 32'h0);
            check("rst_release", 32'(kif.release_pulse), 32'h0);
        end
        reset_n = 1'b1;
        tick();
        check("post_rst_key_out", 32'(kif.key_out), 32'hF);
        check("post_rst_press", 32'(kif.press_pulse), 32'h0);
        check("post_rst_release", 32'(kif.release_pulse), 32'h0);
        kif.key_in = 4'b1111;
        ticks(12);
        check("idle_key_out", 32'(kif.key_out), 32'hF);

        // 2. Single press on channel 0
        clear_counts();
        kif.key_in = 4'b1110;
        ticks(5);
        check("t2_edge5_key_out", 32'(kif.key_out), 32'hF);
        check("t2_edge5_press", 32'(kif.press_pulse), 32'h0);
        tick();
        check("t2_edge6_key_out", 32'(kif.key_out), 32'hE);
        check("t2_edge6_press", 32'(kif.press_pulse), 32'h1);
        check("t2_edge6_release", 32'(kif.release_pulse), 32'h0);
        tick();
        check("t2_edge7_press", 32'(kif.press_pulse), 32'h0);
        check("t2_edge7_key_out", 32'(kif.key_out), 32'hE);

        // 3. Bounce channel 1: low 3, high 1, for 20 cycles
        clear_counts();
        for (int k = 0; k < 20; k++) begin
            kif.key_in = (k % 4 == 3) ? 4'b1110 : 4'b1100;
            tick();
            check("t3_bounce_key_out", 32'(kif.key_out), 32'hE);
        end
        check("t3_bounce_press1", 32'(press_cnt[1]), 32'd0);
        kif.key_in = 4'b1100;
        ticks(10);
        check("t3_hold_key_out", 32'(kif.key_out), 32'hC);
        check("t3_hold_press1", 32'(press_cnt[1]), 32'd1);
        check("t3_hold_release1", 32'(release_cnt[1]), 32'd0);

        // 4. Press then release channel 2
        kif.key_in = 4'b1000;
        ticks(12);
        check("t4_pressed_key_out", 32'(kif.key_out), 32'h8);
        clear_counts();
        kif.key_in = 4'b1100;
        ticks(5);
        check("t4_edge5_key_out", 32'(kif.key_out), 32'h8);
        tick();
        check("t4_edge6_key_out", 32'(kif.key_out), 32'hC);
        check("t4_edge6_release", 32'(kif.release_pulse), 32'h4);
        check("t4_edge6_press", 32'(kif.press_pulse), 32'h0);
        tick();
        check("t4_edge7_release", 32'(kif.release_pulse), 32'h0);

        // 5. All four pressed on the same edge from idle
        kif.key_in = 4'b1111;
        ticks(12);
        check("t5_idle_key_out", 32'(kif.key_out), 32'hF);
        clear_counts();
        kif.key_in = 4'b0000;
        ticks(5);
        check("t5_edge5_key_out", 32'(kif.key_out), 32'hF);
        tick();
        check("t5_edge6_key_out", 32'(kif.key_out), 32'h0);
        check("t5_edge6_press", 32'(kif.press_pulse), 32'hF);
        tick();
        check("t5_edge7_press", 32'(kif.press_pulse), 32'h0);

        // 6. Reset mid-count discards progress
        kif.key_in = 4'b1111;
        ticks(12);
        check("t6_idle_key_out", 32'(kif.key_out), 32'hF);
        kif.key_in = 4'b1110;
        ticks(4);
        reset_n = 1'b0;
        tick();
        check("t6_rst_key_out", 32'(kif.key_out), 32'hF);
        check("t6_rst_press", 32'(kif.press_pulse), 32'h0);
        reset_n = 1'b1;
        ticks(5);
        check("t6_edge5_key_out", 32'(kif.key_out), 32'hF);
        tick();
        check("t6_edge6_key_out", 32'(kif.key_out), 32'hE);
        check("t6_edge6_press", 32'(kif.press_pulse), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
